addr_sequencer: RTL and testbench

//   Parametrised address/program sequencer; successor to the fixed 6-bit free-running address counter.

---
 rtl/addr_seq_pkg.sv | 19 +
 rtl/addr_sequencer_if.sv | 53 +++++
 rtl/addr_step_calc.sv | 48 ++++
 rtl/addr_sequencer.sv | 101 ++++++++++
 tb/tb_addr_sequencer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/addr_seq_pkg.sv
// Shared types for the address sequencer.
// State, mode and direction encodings.
package addr_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } seq_state_t;

    typedef enum logic {
        MODE_WRAP,
        MODE_ONESHOT
    } seq_mode_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/addr_sequencer_if.sv
// Control/status bundle between the datapath
// controller and the address sequencer.
interface addr_sequencer_if #(
    parameter int AW = 6
) ();

    logic          en;
    logic          start;
    logic          load;
    logic [AW-1:0] load_addr;
    logic          dir;
    logic          mode;
    logic [AW-1:0] base;
    logic [AW-1:0] limit;
    logic [AW-1:0] addr;
    logic          tc;
    logic          busy;
    logic          done;
    logic          cfg_err;

    modport master (
        output en,
        output start,
        output load,
        output load_addr,
        output dir,
        output mode,
        output base,
        output limit,
        input  addr,
        input  tc,
        input  busy,
        input  done,
        input  cfg_err
    );

    modport slave (
        input  en,
        input  start,
        input  load,
        input  load_addr,
        input  dir,
        input  mode,
        input  base,
        input  limit,
        output addr,
        output tc,
        output busy,
        output done,
        output cfg_err
    );

endinterface

// File: rtl/addr_step_calc.sv
// Next-address arithmetic: one step up or down,
// clamped to the end bound, plus end detection.
module addr_step_calc
    import addr_seq_pkg::*;
#(
    parameter int AW   = 6,
    parameter int STEP = 1
) (
    input  logic [AW-1:0] addr,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] limit,
    input  logic          dir,
    output logic [AW-1:0] next_addr,
    output logic          at_end
);

    localparam logic [AW:0] STEP_W = (AW+1)'(STEP);

    logic [AW:0] a_w;
    logic [AW:0] b_w;
    logic [AW:0] l_w;
    logic [AW:0] up_w;
    logic [AW:0] dn_w;
    logic [AW:0] lo_w;

    assign a_w  = {1'b0, addr};
    assign b_w  = {1'b0, base};
    assign l_w  = {1'b0, limit};
    assign up_w = a_w + STEP_W;
    assign dn_w = a_w - STEP_W;
    // Below base+STEP a down step would pass base or borrow.
    assign lo_w = b_w + STEP_W;

    always_comb begin
        next_addr = addr;
        at_end    = 1'b0;
        if (dir == DIR_DOWN) begin
            at_end = (addr <= base);
            if (a_w < lo_w) next_addr = base;
            else            next_addr = dn_w[AW-1:0];
        end else begin
            at_end = (addr >= limit);
            if (up_w > l_w) next_addr = limit;
            else            next_addr = up_w[AW-1:0];
        end
    end

endmodule

// File: rtl/addr_sequencer.sv
// Programmable address sequencer: bounded up/down
// stepping with wrap or one-shot, jump and stall.
module addr_sequencer
    import addr_seq_pkg::*;
#(
    parameter int AW         = 6,
    parameter int STEP       = 1,
    parameter int RESET_ADDR = 0,
    parameter int AUTO_START = 1
) (
    input logic             clk,
    input logic             rst,
    addr_sequencer_if.slave bus
);

    localparam logic [AW-1:0] RST_A = AW'(RESET_ADDR);
    localparam seq_state_t    RST_S =
        (AUTO_START != 0) ? S_RUN : S_IDLE;

    seq_state_t    state;
    seq_state_t    state_d;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;
    logic [AW-1:0] nxt;
    logic [AW-1:0] start_pt;
    logic          tc_q;
    logic          tc_d;
    logic          at_end;
    logic          cfg_err;
    logic          run;
    logic          oneshot;
    logic          do_load;
    logic          do_start;
    logic          do_step;

    addr_step_calc #(
        .AW   (AW),
        .STEP (STEP)
    ) u_calc (
        .addr      (addr_q),
        .base      (bus.base),
        .limit     (bus.limit),
        .dir       (bus.dir),
        .next_addr (nxt),
        .at_end    (at_end)
    );

    assign cfg_err  = (bus.base > bus.limit);
    assign run      = (state == S_RUN);
    assign oneshot  = (seq_mode_t'(bus.mode) == MODE_ONESHOT);
    assign start_pt = (bus.dir == DIR_DOWN) ? bus.limit : bus.base;

    // Mutually exclusive actions encode load > start > step.
    assign do_load  = bus.load;
    assign do_start = bus.start & ~bus.load & ~run;
    assign do_step  = run & bus.en & ~cfg_err & ~bus.load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RST_S;
            addr_q <= RST_A;
            tc_q   <= 1'b0;
        end else begin
            state  <= state_d;
            addr_q <= addr_d;
            tc_q   <= tc_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (1'b1)
            do_load:  state_d = S_RUN;
            do_start: state_d = S_RUN;
            do_step:  if (at_end && oneshot) state_d = S_DONE;
            default:  state_d = state;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        tc_d   = 1'b0;
        unique case (1'b1)
            do_load:  addr_d = bus.load_addr;
            do_start: addr_d = start_pt;
            do_step: begin
                tc_d = at_end;
                if (!at_end)      addr_d = nxt;
                else if (!oneshot) addr_d = start_pt;
            end
            default:  addr_d = addr_q;
        endcase
    end

    assign bus.addr    = addr_q;
    assign bus.tc      = tc_q;
    assign bus.busy    = (state == S_RUN);
    assign bus.done    = (state == S_DONE);
    assign bus.cfg_err = cfg_err;

endmodule

// File: tb/tb_addr_sequencer.sv
// Scoreboard bench for addr_sequencer: a default free-run
// instance and a STEP=3 one-shot instance.
module tb_addr_sequencer;

    typedef struct {
        string      nm;
        logic [5:0] a;
        logic       tc;
        logic       busy;
        logic       done;
        logic       cerr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    addr_sequencer_if #(.AW(6)) ia ();
    addr_sequencer_if #(.AW(6)) ib ();

    addr_sequencer #(
        .AW(6), .STEP(1), .RESET_ADDR(0), .AUTO_START(1)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia.slave)
    );

    addr_sequencer #(
        .AW(6), .STEP(3), .RESET_ADDR(0), .AUTO_START(0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib.slave)
    );

    function automatic exp_t mk(
        input string nm, input int a,
        input bit tc, input bit b, input bit d, input bit c);
        exp_t e;
        e.nm   = nm;
        e.a    = 6'(a);
        e.tc   = tc;
        e.busy = b;
        e.done = d;
        e.cerr = c;
        return e;
    endfunction

    task automatic chk(
        input string who, input exp_t e,
        input logic [5:0] a, input logic tc,
        input logic b, input logic d, input logic c);
        total++;
        if (a === e.a && tc === e.tc && b === e.busy &&
            d === e.done && c === e.cerr) begin
            passed++;
        end else begin
            $display("FAIL %s/%s: got a=%0d tc=%b busy=%b done=%b cerr=%b want a=%0d tc=%b busy=%b done=%b cerr=%b",
                who, e.nm, a, tc, b, d, c,
                e.a, e.tc, e.busy, e.done, e.cerr);
        end
    endtask

    // Monitor: pop and compare whenever an expectation is pending.
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("A", e, ia.addr, ia.tc, ia.busy, ia.done, ia.cfg_err);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("B", e, ib.addr, ib.tc, ib.busy, ib.done, ib.cfg_err);
        end
    end

    task automatic tk(input int d, input exp_t e);
        @(posedge clk);
        #1;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        ia.en = 1'b1; ia.start = 1'b0; ia.load = 1'b0;
        ia.load_addr = '0; ia.dir = 1'b0; ia.mode = 1'b0;
        ia.base = 6'd0; ia.limit = 6'd63;
        ib.en = 1'b1; ib.start = 1'b0; ib.load = 1'b0;
        ib.load_addr = '0; ib.dir = 1'b0; ib.mode = 1'b1;
        ib.base = 6'd2; ib.limit = 6'd10;
        rst = 1'b1;
        q0.push_back(mk("rst", 0, 0, 1, 0, 0));
        q1.push_back(mk("rst", 0, 0, 0, 0, 0));
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Legacy free-running 0..63 wrap.
        for (int i = 1; i < 64; i++) tk(0, mk("cnt", i, 0, 1, 0, 0));
        tk(0, mk("wrap", 0, 1, 1, 0, 0));
        for (int i = 1; i < 8; i++) tk(0, mk("cnt2", i, 0, 1, 0, 0));

        // Jump mid-run, then resume.
        ia.load = 1'b1; ia.load_addr = 6'd20;
        tk(0, mk("load", 20, 0, 1, 0, 0));
        ia.load = 1'b0;
        tk(0, mk("resume", 21, 0, 1, 0, 0));
        tk(0, mk("resume", 22, 0, 1, 0, 0));

        // Stall, then asynchronous reset between edges.
        ia.load = 1'b1; ia.load_addr = 6'd12;
        tk(0, mk("load12", 12, 0, 1, 0, 0));
        ia.load = 1'b0; ia.en = 1'b0;
        repeat (5) tk(0, mk("stall", 12, 0, 1, 0, 0));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        q0.push_back(mk("async_rst", 0, 0, 1, 0, 0));
        @(negedge clk);
        #1;
        rst = 1'b0; ia.en = 1'b1;
        tk(0, mk("post_rst", 1, 0, 1, 0, 0));

        // Bad config freezes stepping; load still honoured.
        ia.base = 6'd10; ia.limit = 6'd5;
        tk(0, mk("cfg_err", 1, 0, 1, 0, 1));
        tk(0, mk("cfg_err", 1, 0, 1, 0, 1));
        ia.load = 1'b1; ia.load_addr = 6'd12;
        tk(0, mk("cfg_load", 12, 0, 1, 0, 1));
        ia.load = 1'b0;
        tk(0, mk("cfg_hold", 12, 0, 1, 0, 1));
        ia.limit = 6'd15;
        tk(0, mk("cfg_ok", 13, 0, 1, 0, 0));
        tk(0, mk("cfg_ok", 14, 0, 1, 0, 0));
        tk(0, mk("cfg_ok", 15, 0, 1, 0, 0));
        tk(0, mk("base_wrap", 10, 1, 1, 0, 0));

        // Down WRAP over 4..7; start ignored while running.
        ia.dir = 1'b1; ia.base = 6'd4; ia.limit = 6'd7;
        ia.load = 1'b1; ia.load_addr = 6'd5;
        tk(0, mk("dn_load", 5, 0, 1, 0, 0));
        ia.load = 1'b0;
        tk(0, mk("dn", 4, 0, 1, 0, 0));
        tk(0, mk("dn_wrap", 7, 1, 1, 0, 0));
        ia.start = 1'b1;
        tk(0, mk("start_in_run", 6, 0, 1, 0, 0));
        ia.start = 1'b0;
        tk(0, mk("dn", 5, 0, 1, 0, 0));

        // Single-address window: every step is terminal.
        ia.dir = 1'b0; ia.base = 6'd9; ia.limit = 6'd9;
        ia.load = 1'b1; ia.load_addr = 6'd9;
        tk(0, mk("eq_load", 9, 0, 1, 0, 0));
        ia.load = 1'b0;
        tk(0, mk("eq_tc", 9, 1, 1, 0, 0));
        tk(0, mk("eq_tc", 9, 1, 1, 0, 0));

        // STEP=3 one-shot instance, up with clamp.
        tk(1, mk("idle", 0, 0, 0, 0, 0));
        ib.start = 1'b1;
        tk(1, mk("start", 2, 0, 1, 0, 0));
        ib.start = 1'b0;
        tk(1, mk("up3", 5, 0, 1, 0, 0));
        tk(1, mk("up3", 8, 0, 1, 0, 0));
        tk(1, mk("clamp", 10, 0, 1, 0, 0));
        tk(1, mk("os_end", 10, 1, 0, 1, 0));
        tk(1, mk("done_hold", 10, 0, 0, 1, 0));

        // Down one-shot through a borrow at zero.
        ib.dir = 1'b1; ib.base = 6'd0; ib.limit = 6'd10;
        ib.start = 1'b1;
        tk(1, mk("dn_start", 10, 0, 1, 0, 0));
        ib.start = 1'b0;
        tk(1, mk("dn3", 7, 0, 1, 0, 0));
        tk(1, mk("dn3", 4, 0, 1, 0, 0));
        tk(1, mk("dn3", 1, 0, 1, 0, 0));
        tk(1, mk("borrow", 0, 0, 1, 0, 0));
        tk(1, mk("dn_end", 0, 1, 0, 1, 0));
        ib.load = 1'b1; ib.load_addr = 6'd33;
        tk(1, mk("load_done", 33, 0, 1, 0, 0));
        ib.load = 1'b0;

        total++;
        if (q0.size() + q1.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending, want 0",
                      q0.size() + q1.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
